// File: rtl/score_argmax_pkg.sv
// Shared types for score_argmax: result record, FSM states and widths.
// SCORE_ARGMAX_MARGIN_EN adds a winner-minus-runner-up margin to each result.
package score_argmax_pkg;
   localparam int DATA_WIDTH  = 32;
   localparam int NUM_CLASSES = 10;
   localparam int IMG_NUM     = 10;
   localparam int CLASS_W     = 4;
   localparam int IMG_W       = $clog2(IMG_NUM);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DRAIN, ST_DONE} state_e;

   typedef struct packed {
      logic [IMG_W-1:0]      img;
      logic [CLASS_W-1:0]    cls;
      logic [DATA_WIDTH-1:0] score;
`ifdef SCORE_ARGMAX_MARGIN_EN
      logic [DATA_WIDTH-1:0] margin;
`endif
   } pred_t;

`ifdef SCORE_ARGMAX_MARGIN_EN
   // Difference is evaluated one bit wider so it cannot wrap before saturating.
   function automatic logic [DATA_WIDTH-1:0] margin_sat(input logic signed [DATA_WIDTH-1:0] win,
                                                        input logic signed [DATA_WIDTH-1:0] run);
      logic signed [DATA_WIDTH:0] diff;
      diff = $signed({win[DATA_WIDTH-1], win}) - $signed({run[DATA_WIDTH-1], run});
      return diff[DATA_WIDTH] ? '1 : diff[DATA_WIDTH-1:0];
   endfunction
`endif
endpackage

// File: rtl/pred_fifo.sv
// Synchronous result FIFO of pred_t; a pop in the same cycle frees room for a push.
module pred_fifo
   import score_argmax_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  push_i,
   input  pred_t data_i,
   input  logic  pop_i,
   output pred_t data_o,
   output logic  full_o,
   output logic  empty_o
);
   localparam int AW = $clog2(DEPTH);

   pred_t         mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, rd_ptr_q;
   logic          do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
            wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end
endmodule

// File: rtl/score_argmax.sv
// Snoops y_buf score writes, keeps a running signed argmax per image, queues results.
// SCORE_ARGMAX_MARGIN_EN adds pred_margin_o (winner minus runner-up, saturating).
module score_argmax
   import score_argmax_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  y_buf_en_i,
   input  logic                  y_buf_wr_en_i,
   input  logic [ADDR_WIDTH-1:0] y_buf_addr_i,
   input  logic [DATA_WIDTH-1:0] y_buf_data_i,
   output logic                  pred_valid_o,
   input  logic                  pred_ready_i,
   output logic [IMG_W-1:0]      pred_img_o,
   output logic [CLASS_W-1:0]    pred_class_o,
   output logic [DATA_WIDTH-1:0] pred_score_o,
`ifdef SCORE_ARGMAX_MARGIN_EN
   output logic [DATA_WIDTH-1:0] pred_margin_o,
`endif
   output logic                  all_done_o,
   output logic                  overflow_o,
   output logic                  seq_err_o
);
   state_e                        state_q, state_d;
   logic [IMG_W-1:0]              img_q, img_d, eff_img;
   logic [CLASS_W-1:0]            cls_q, cls_d, eff_cls, idx_q, idx_d;
   logic signed [DATA_WIDTH-1:0]  max_q, max_d, sec_q, sec_d, score;
   logic                          seq_err_q, seq_err_d, ovf_q, ovf_d;
   logic                          beat, restart, use_beat, push, pop, full, empty;
   logic [ADDR_WIDTH-1:0]         exp_addr;
   pred_t                         push_data, head;

   assign beat     = y_buf_en_i & y_buf_wr_en_i;
   assign restart  = beat & (y_buf_addr_i == '0);
   assign score    = $signed(y_buf_data_i);
   assign exp_addr = ADDR_WIDTH'((int'(img_q) * NUM_CLASSES + int'(cls_q)) * 4);
   assign eff_img  = restart ? '0 : img_q;
   assign eff_cls  = restart ? '0 : cls_q;
   assign pop      = pred_valid_o & pred_ready_i;

   always_comb begin
      state_d   = state_q;
      img_d     = img_q;
      cls_d     = cls_q;
      max_d     = max_q;
      sec_d     = sec_q;
      idx_d     = idx_q;
      seq_err_d = seq_err_q;
      use_beat  = 1'b0;
      push      = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_ACCUM: begin
            use_beat = beat;
            if (beat && !restart && (y_buf_addr_i != exp_addr)) seq_err_d = 1'b1;
         end
         ST_DRAIN, ST_DONE: begin
            use_beat = restart;
            if (beat && !restart) seq_err_d = 1'b1;
            if (state_q == ST_DRAIN && empty) state_d = ST_DONE;
         end
         default: ;
      endcase

      if (use_beat) begin
         // Strict compare: on a tie the lower class index already held wins.
         if (eff_cls == '0) begin
            max_d = score;
            idx_d = '0;
            sec_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
         end else if (score > max_q) begin
            sec_d = max_q;
            max_d = score;
            idx_d = eff_cls;
         end else if (score > sec_q) begin
            sec_d = score;
         end
         if (eff_cls == CLASS_W'(NUM_CLASSES-1)) begin
            push    = 1'b1;
            cls_d   = '0;
            img_d   = eff_img + IMG_W'(1);
            state_d = (eff_img == IMG_W'(IMG_NUM-1)) ? ST_DRAIN : ST_ACCUM;
         end else begin
            cls_d   = eff_cls + CLASS_W'(1);
            img_d   = eff_img;
            state_d = ST_ACCUM;
         end
      end
      ovf_d = ovf_q | (push & full & ~pop);
   end

   always_comb begin
      push_data        = '0;
      push_data.img    = eff_img;
      push_data.cls    = idx_d;
      push_data.score  = max_d;
`ifdef SCORE_ARGMAX_MARGIN_EN
      push_data.margin = margin_sat(max_d, sec_d);
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         img_q     <= '0;
         cls_q     <= '0;
         max_q     <= '0;
         sec_q     <= '0;
         idx_q     <= '0;
         seq_err_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         img_q     <= img_d;
         cls_q     <= cls_d;
         max_q     <= max_d;
         sec_q     <= sec_d;
         idx_q     <= idx_d;
         seq_err_q <= seq_err_d;
         ovf_q     <= ovf_d;
      end
   end

   pred_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .data_i  (push_data),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   assign pred_valid_o  = ~empty;
   assign pred_img_o    = head.img;
   assign pred_class_o  = head.cls;
   assign pred_score_o  = head.score;
`ifdef SCORE_ARGMAX_MARGIN_EN
   assign pred_margin_o = head.margin;
`endif
   assign all_done_o    = (state_q == ST_DONE);
   assign overflow_o    = ovf_q;
   assign seq_err_o     = seq_err_q;
endmodule
